// File: rtl/ad9226_pkg.sv
// Shared ADC sample-format constants and the FIFO reader state set, used by the
// packing writer, this reader and the W5500 controller.
package ad9226_pkg;

   localparam int ADC_BITS_DEF = 12;
   localparam int SAMPLES_DEF  = 4;

   function automatic int getWordW(input int adcBits, input int samples);
      return adcBits * samples;
   endfunction

   function automatic int getBytesPerWord(input int adcBits, input int samples);
      return (adcBits * samples) / 8;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      READ,
      LOAD,
      SEND
   } readerState_t;

endpackage

// File: rtl/ad9226_fifo_reader.sv
// Pops packed ADC sample words from the sample FIFO and streams them MSB-first as
// bytes with valid/ready, flagging the final byte of every frame for the W5500 side.
module ad9226_fifo_reader
   import ad9226_pkg::*;
#(
   parameter int ADC_BITS        = ADC_BITS_DEF,
   parameter int SAMPLES         = SAMPLES_DEF,
   parameter int WORDS_PER_FRAME = 256
) (
   input  logic                         sys_clk,
   input  logic                         reset_n,
   input  logic                         fifo_empty,
   input  logic [ADC_BITS*SAMPLES-1:0]  fifo_data,
   output logic                         fifo_read_enable,
   input  logic                         byte_ready,
   output logic                         byte_valid,
   output logic [7:0]                   byte_data,
   output logic                         byte_last,
   output logic                         busy
);

   localparam int WORD_W         = getWordW(ADC_BITS, SAMPLES);
   localparam int BYTES_PER_WORD = getBytesPerWord(ADC_BITS, SAMPLES);
   localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int CNT_W          = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FRAME - 1);

   generate
      if ((WORD_W % 8) != 0 || WORD_W == 0) begin : g_badWordWidth
         $error("ad9226_fifo_reader: ADC_BITS*SAMPLES must be a nonzero multiple of 8");
      end
      if (WORDS_PER_FRAME < 1) begin : g_badFrameLength
         $error("ad9226_fifo_reader: WORDS_PER_FRAME must be at least 1");
      end
   endgenerate

   readerState_t        r_state, w_stateNext;
   logic                r_readEn, w_readEnNext;
   logic                r_valid, w_validNext;
   logic [7:0]          r_data, w_dataNext;
   logic                r_last, w_lastNext;
   logic                r_busy, w_busyNext;
   logic [WORD_W-1:0]   r_shift, w_shiftNext, w_shifted;
   logic [IDX_W-1:0]    r_byteIdx, w_byteIdxNext;
   logic [CNT_W-1:0]    r_wordCnt, w_wordCntNext;
   logic                w_frameEnd;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_readEn  <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_last    <= 1'b0;
         r_busy    <= 1'b0;
         r_shift   <= '0;
         r_byteIdx <= '0;
         r_wordCnt <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_readEn  <= w_readEnNext;
         r_valid   <= w_validNext;
         r_data    <= w_dataNext;
         r_last    <= w_lastNext;
         r_busy    <= w_busyNext;
         r_shift   <= w_shiftNext;
         r_byteIdx <= w_byteIdxNext;
         r_wordCnt <= w_wordCntNext;
      end
   end

   // Every output is computed here one cycle ahead so it leaves the block from a flop.
   always_comb begin
      w_stateNext   = r_state;
      w_readEnNext  = 1'b0;
      w_validNext   = r_valid;
      w_dataNext    = r_data;
      w_lastNext    = r_last;
      w_shiftNext   = r_shift;
      w_byteIdxNext = r_byteIdx;
      w_wordCntNext = r_wordCnt;
      w_shifted     = r_shift << 8;
      w_frameEnd    = (r_wordCnt == LAST_WORD);

      case (r_state)
         IDLE: begin
            if (!fifo_empty) begin
               w_readEnNext = 1'b1;
               w_stateNext  = READ;
            end
         end
         READ: begin
            w_stateNext = LOAD;
         end
         LOAD: begin
            w_shiftNext   = fifo_data;
            w_validNext   = 1'b1;
            w_dataNext    = fifo_data[WORD_W-1 -: 8];
            w_byteIdxNext = '0;
            w_lastNext    = (BYTES_PER_WORD == 1) && w_frameEnd;
            w_stateNext   = SEND;
         end
         SEND: begin
            if (r_valid && byte_ready) begin
               if (r_byteIdx != LAST_IDX) begin
                  w_shiftNext   = w_shifted;
                  w_dataNext    = w_shifted[WORD_W-1 -: 8];
                  w_byteIdxNext = r_byteIdx + IDX_W'(1);
                  w_lastNext    = ((r_byteIdx + IDX_W'(1)) == LAST_IDX) && w_frameEnd;
               end else begin
                  w_validNext   = 1'b0;
                  w_lastNext    = 1'b0;
                  w_wordCntNext = w_frameEnd ? '0 : r_wordCnt + CNT_W'(1);
                  w_stateNext   = IDLE;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

      w_busyNext = (w_stateNext != IDLE);
   end

   assign fifo_read_enable = r_readEn;
   assign byte_valid       = r_valid;
   assign byte_data        = r_data;
   assign byte_last        = r_last;
   assign busy             = r_busy;

endmodule

// File: tb/tb_ad9226_fifo_reader.sv
// Directed scoreboard bench for ad9226_fifo_reader: dutA uses the default 256-word
// frame, dutB a 2-word frame for the framing checks.
`timescale 1ns/1ps
module tb_ad9226_fifo_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nFail   = 0;

   logic        rstnA, emptyA, rdA, readyA, validA, lastA, busyA;
   logic [47:0] fifoDataA;
   logic [7:0]  dataA;
   logic [47:0] fifoQA[$];
   logic [8:0]  expA[$];
   logic [8:0]  popA;
   int          frmA = 0, nReadsA = 0, nBytesA = 0, nLastA = 0;
   logic        heldA = 1'b0;
   logic [9:0]  heldValA;

   logic        rstnB, emptyB, rdB, readyB, validB, lastB, busyB;
   logic [47:0] fifoDataB;
   logic [7:0]  dataB;
   logic [47:0] fifoQB[$];
   logic [8:0]  expB[$];
   logic [8:0]  popB;
   int          frmB = 0, nReadsB = 0, nBytesB = 0, nLastB = 0;

   logic [7:0]  refBytes[6];
   logic        anyActivity;
   int          cyc;

   ad9226_fifo_reader #(.ADC_BITS(12), .SAMPLES(4), .WORDS_PER_FRAME(256)) dutA (
      .sys_clk(clk), .reset_n(rstnA), .fifo_empty(emptyA), .fifo_data(fifoDataA),
      .fifo_read_enable(rdA), .byte_ready(readyA), .byte_valid(validA),
      .byte_data(dataA), .byte_last(lastA), .busy(busyA));

   ad9226_fifo_reader #(.ADC_BITS(12), .SAMPLES(4), .WORDS_PER_FRAME(2)) dutB (
      .sys_clk(clk), .reset_n(rstnB), .fifo_empty(emptyB), .fifo_data(fifoDataB),
      .fifo_read_enable(rdB), .byte_ready(readyB), .byte_valid(validB),
      .byte_data(dataB), .byte_last(lastB), .busy(busyB));

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue a word in the FIFO model and its six expected bytes in the scoreboard.
   task automatic applyStimulusA(input logic [47:0] w);
      fifoQA.push_back(w);
      for (int b = 0; b < 6; b++)
         expA.push_back({(frmA == 255 && b == 5), w[47-8*b -: 8]});
      frmA = (frmA + 1) % 256;
   endtask

   task automatic applyStimulusB(input logic [47:0] w);
      fifoQB.push_back(w);
      for (int b = 0; b < 6; b++)
         expB.push_back({(frmB == 1 && b == 5), w[47-8*b -: 8]});
      frmB = (frmB + 1) % 2;
   endtask

   // FIFO empty flags follow the model queues shortly after each clock edge.
   always begin
      @(posedge clk);
      #2;
      emptyA = (fifoQA.size() == 0);
      emptyB = (fifoQB.size() == 0);
   end

   // FIFO read model plus output monitor for dutA.
   always @(negedge clk) begin
      if (!rstnA) begin
         heldA = 1'b0;
      end else begin
         if (rdA) begin
            checkOutput("oneWordInFlightA", 64'(nBytesA), 64'(nReadsA * 6));
            checkOutput("readWhenNotEmptyA", 64'(fifoQA.size() != 0), 64'(1));
            if (fifoQA.size() != 0) fifoDataA = fifoQA.pop_front();
            nReadsA++;
         end
         if (heldA)
            checkOutput("holdWhileStalledA", 64'({validA, lastA, dataA}), 64'(heldValA));
         if (validA && readyA) begin
            checkOutput("byteExpectedA", 64'(expA.size() != 0), 64'(1));
            if (expA.size() != 0) begin
               popA = expA.pop_front();
               checkOutput("byteA", 64'({lastA, dataA}), 64'(popA));
            end
            nBytesA++;
            if (lastA) nLastA++;
         end
         heldA    = validA && !readyA;
         heldValA = {validA, lastA, dataA};
      end
   end

   always @(negedge clk) begin
      if (rstnB) begin
         if (rdB) begin
            checkOutput("oneWordInFlightB", 64'(nBytesB), 64'(nReadsB * 6));
            checkOutput("readWhenNotEmptyB", 64'(fifoQB.size() != 0), 64'(1));
            if (fifoQB.size() != 0) fifoDataB = fifoQB.pop_front();
            nReadsB++;
         end
         if (validB && readyB) begin
            checkOutput("byteExpectedB", 64'(expB.size() != 0), 64'(1));
            if (expB.size() != 0) begin
               popB = expB.pop_front();
               checkOutput("byteB", 64'({lastB, dataB}), 64'(popB));
            end
            nBytesB++;
            if (lastB) nLastB++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      refBytes = '{8'hAB, 8'hC1, 8'h23, 8'h45, 8'h67, 8'h89};
      rstnA = 1'b0; rstnB = 1'b0; readyA = 1'b0; readyB = 1'b0;
      emptyA = 1'b1; emptyB = 1'b1; fifoDataA = '0; fifoDataB = '0;
      #1;
      checkOutput("resetOutputsA", 64'({rdA, validA, dataA, lastA, busyA}), '0);
      checkOutput("resetOutputsB", 64'({rdB, validB, dataB, lastB, busyB}), '0);
      repeat (3) @(posedge clk);
      #1 rstnA = 1'b1; rstnB = 1'b1;
      @(negedge clk);
      checkOutput("idleAfterRelease", 64'({rdA, validA, busyA}), '0);

      // Single word, byte_ready held high: exact pulse and byte timing.
      @(posedge clk);
      #1 readyA = 1'b1;
      applyStimulusA(48'hABC1_2345_6789);
      @(negedge clk);
      checkOutput("noReadBeforeSample", 64'(rdA), '0);
      @(negedge clk);
      checkOutput("readPulseOn", 64'({rdA, validA, busyA}), 64'(3'b101));
      @(negedge clk);
      checkOutput("readPulseOff", 64'({rdA, validA, busyA}), 64'(3'b001));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput($sformatf("byteStream%0d", i), 64'({validA, lastA, dataA}), 64'({2'b10, refBytes[i]}));
      end
      @(negedge clk);
      checkOutput("idleAfterWord", 64'({rdA, validA, busyA}), '0);

      // Empty FIFO: nothing may move for 100 cycles.
      anyActivity = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         anyActivity = anyActivity | rdA | validA | busyA;
      end
      checkOutput("quietWhileEmpty", 64'(anyActivity), '0);

      // Backpressure: ready pattern 1,0,0 repeating over two words.
      applyStimulusA(48'hABC1_2345_6789);
      applyStimulusA(48'h0123_4567_89AB);
      for (int c = 0; c < 300 && (expA.size() != 0 || busyA); c++) begin
         @(posedge clk);
         #1 readyA = (c % 3 == 0);
      end
      readyA = 1'b1;
      checkOutput("backpressureDrained", 64'(expA.size()), '0);
      checkOutput("backpressureReads", 64'(nReadsA), 64'(3));
      checkOutput("backpressureBytes", 64'(nBytesA), 64'(18));

      // Asynchronous reset after the third byte of a word has been accepted.
      applyStimulusA(48'hFEDC_BA98_7654);
      for (int c = 0; c < 50 && nBytesA < 21; c++) @(posedge clk);
      checkOutput("bytesBeforeReset", 64'(nBytesA), 64'(21));
      #3 rstnA = 1'b0;
      #1 checkOutput("asyncResetOutputs", 64'({rdA, validA, dataA, lastA, busyA}), '0);
      expA.delete();
      frmA = 0; nReadsA = 0; nBytesA = 0; nLastA = 0;
      for (int i = 0; i < 256; i++) applyStimulusA({$urandom, $urandom}[47:0]);
      repeat (2) @(posedge clk);

      // Throughput after release: 256 back-to-back words, frame counter restarted.
      #1 rstnA = 1'b1;
      #1 checkOutput("noReadInReleaseCycle", 64'(rdA), '0);
      cyc = 0;
      while (nBytesA < 1536 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("throughputCycles", 64'(cyc >= 2301 && cyc <= 2307), 64'(1));
      repeat (3) @(negedge clk);
      checkOutput("throughputReads", 64'(nReadsA), 64'(256));
      checkOutput("throughputBytes", 64'(nBytesA), 64'(1536));
      checkOutput("throughputLast", 64'(nLastA), 64'(1));
      checkOutput("throughputDrained", 64'(expA.size()), '0);
      checkOutput("throughputIdle", 64'({rdA, validA, busyA}), '0);

      // Framing on the 2-word-frame instance: five words, byte_last on bytes 12 and 24.
      @(posedge clk);
      #1 readyB = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulusB(48'h1000_0000_0000 + 48'(i * 48'h0101_0101_0101));
      for (int c = 0; c < 300 && (expB.size() != 0 || busyB); c++) @(posedge clk);
      @(negedge clk);
      checkOutput("framingDrained", 64'(expB.size()), '0);
      checkOutput("framingReads", 64'(nReadsB), 64'(5));
      checkOutput("framingBytes", 64'(nBytesB), 64'(30));
      checkOutput("framingLastCount", 64'(nLastB), 64'(2));

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
